// File: rtl/fc_scheduler.sv
// rtl/fc_scheduler.sv - sequences the FC datapath over N_OUT neurons, streams results and tracks the argmax
// Weight rows are fetched one per neuron; results leave on a valid/ready port.
module fc_scheduler #(
    parameter int N_OUT  = 10,
    parameter int ADDR_W = 4,
    parameter int VEC_W  = 216
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [VEC_W-1:0]  pool_in,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [VEC_W-1:0]  w_rd_data,
    output logic [VEC_W-1:0]  pool_lin,
    output logic [VEC_W-1:0]  weight_lin,
    input  logic [7:0]        ans,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_idx,
    output logic [7:0]        res_data,
    output logic [ADDR_W-1:0] class_idx,
    output logic [7:0]        class_max
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EVAL  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_OUT - 1);
    localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_k;
    logic [VEC_W-1:0]    r_pool;
    logic [VEC_W-1:0]    r_weight;
    logic [7:0]          r_res_data;
    logic [ADDR_W-1:0]   r_res_idx;
    logic                r_res_valid;
    logic [ADDR_W-1:0]   r_class_idx;
    logic [7:0]          r_class_max;
    logic                r_done;
    logic                r_busy;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;

    logic                w_handshake;
    logic                w_better;

    assign w_handshake = r_res_valid & res_ready;
    // Strict compare: an equal value later in the sweep never displaces the earlier index.
    assign w_better    = $signed(ans) > $signed(r_class_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_pool      <= '0;
            r_weight    <= '0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
            r_res_valid <= 1'b0;
            r_class_idx <= '0;
            r_class_max <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pool      <= pool_in;
                        r_k         <= '0;
                        r_class_max <= 8'h80;
                        r_class_idx <= '0;
                        r_busy      <= 1'b1;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= '0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_weight <= w_rd_data;
                    r_state  <= S_EVAL;
                end
                S_EVAL: begin
                    r_res_data  <= ans;
                    r_res_idx   <= r_k;
                    r_res_valid <= 1'b1;
                    if (w_better) begin
                        r_class_max <= ans;
                        r_class_idx <= r_k;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    // Outputs are held until the consumer takes the result.
                    if (w_handshake) begin
                        r_res_valid <= 1'b0;
                        if (r_k == K_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_k       <= r_k + K_ONE;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_k + K_ONE;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign w_rd_en    = r_rd_en;
    assign w_rd_addr  = r_rd_addr;
    assign pool_lin   = r_pool;
    assign weight_lin = r_weight;
    assign res_valid  = r_res_valid;
    assign res_idx    = r_res_idx;
    assign res_data   = r_res_data;
    assign class_idx  = r_class_idx;
    assign class_max  = r_class_max;

endmodule

// File: tb/tb_fc_scheduler.sv
// tb/tb_fc_scheduler.sv - directed, table-driven bench for fc_scheduler
module tb_fc_scheduler;
    localparam int N_OUT  = 10;
    localparam int ADDR_W = 4;
    localparam int VEC_W  = 216;

    logic              clk = 1'b0;
    logic              rst, start, busy, done, w_rd_en, res_valid, res_ready;
    logic [ADDR_W-1:0] w_rd_addr, res_idx, class_idx;
    logic [VEC_W-1:0]  pool_in, w_rd_data, pool_lin, weight_lin;
    logic [7:0]        ans, res_data, class_max;

    fc_scheduler #(.N_OUT(N_OUT), .ADDR_W(ADDR_W), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pool_in(pool_in), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .pool_lin(pool_lin), .weight_lin(weight_lin), .ans(ans),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
        .class_idx(class_idx), .class_max(class_max)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pool;
        logic        tie;
        logic [79:0] exp;
        logic [3:0]  cidx;
        logic [7:0]  cmax;
    } vec_t;

    vec_t             tbl [3];
    logic [VEC_W-1:0] mem [N_OUT];
    bit               dp_real = 1'b0;
    int               cyc = 0;
    int               t0 = 0;
    int               px1 = -1, px2 = -1;
    int               done_cnt = 0;
    int               n_chk = 0, n_pass = 0;

    function automatic logic [VEC_W-1:0] rvec();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        return t[VEC_W-1:0];
    endfunction

    function automatic logic [7:0] dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        int s, p, q;
        logic [31:0] t;
        s = 0;
        for (int i = 0; i < 27; i++) begin
            p = int'($signed(a[i*8 +: 8]));
            q = int'($signed(b[i*8 +: 8]));
            s += p * q;
        end
        t = s >>> 7;
        return t[7:0];
    endfunction

    always_comb begin
        ans = weight_lin[7:0] + pool_lin[7:0];
        if (dp_real) ans = dot(pool_lin, weight_lin);
    end

    // Weight memory: one-cycle read latency, junk on the bus when not reading.
    always @(posedge clk) begin
        if (w_rd_en && (int'(w_rd_addr) < N_OUT)) w_rd_data <= mem[w_rd_addr];
        else w_rd_data <= rvec();
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
    endtask

    task automatic step();
        int r;
        @(negedge clk);
        r = cyc - t0;
        start = (r == px1) || (r == px2);
    endtask

    task automatic load_rows(input logic [7:0] pool, input logic tie);
        logic [7:0] b;
        for (int k = 0; k < N_OUT; k++) begin
            b = 8'(k * 3);
            if (tie && (k == 2 || k == 7)) b = 8'h40;
            mem[k] = {27{b}};
        end
        pool_in = {27{pool}};
    endtask

    task automatic run_frame(input logic [VEC_W-1:0] pv, input logic [79:0] exp,
                             input logic [3:0] cidx, input logic [7:0] cmax,
                             input int stall_k, input int stall_n, input int x1, input int x2);
        int shift, guard, dc0;
        shift = 0;
        dc0 = done_cnt;
        pool_in = pv;
        start = 1'b1;
        t0 = cyc;
        px1 = x1;
        px2 = x2;
        step();
        chk("busy_c1", busy, 1);
        chk("pool_lin_c1", pool_lin == pv, 1);
        chk("rd_en_c1", w_rd_en, 1);
        for (int k = 0; k < N_OUT; k++) begin
            guard = 0;
            while (!res_valid && guard < 40) begin
                step();
                guard++;
            end
            chk("valid_cycle", cyc - t0, 4 * k + 4 + shift);
            chk("res_idx", res_idx, k);
            chk("res_data", res_data, exp[k*8 +: 8]);
            if (k == stall_k) begin
                res_ready = 1'b0;
                repeat (stall_n) begin
                    step();
                    chk("stall_hold", {res_valid, res_idx, res_data}, {1'b1, 4'(k), exp[k*8 +: 8]});
                end
                res_ready = 1'b1;
                shift += stall_n;
            end
            step();
        end
        chk("done_pulse", done, 1);
        chk("res_valid_at_done", res_valid, 0);
        chk("class_idx", class_idx, cidx);
        chk("class_max", class_max, cmax);
        step();
        chk("busy_fall", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - dc0, 1);
        px1 = -1;
        px2 = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [79:0]      e;
        logic [VEC_W-1:0] pv;
        int               dc0, guard, bi;
        logic [7:0]       bm;

        tbl[0] = '{pool: 8'd5, tie: 1'b0,
                   exp: {8'd32, 8'd29, 8'd26, 8'd23, 8'd20, 8'd17, 8'd14, 8'd11, 8'd8, 8'd5},
                   cidx: 4'd9, cmax: 8'd32};
        tbl[1] = '{pool: 8'hF0, tie: 1'b0,
                   exp: {8'h0B, 8'h08, 8'h05, 8'h02, 8'hFF, 8'hFC, 8'hF9, 8'hF6, 8'hF3, 8'hF0},
                   cidx: 4'd9, cmax: 8'h0B};
        tbl[2] = '{pool: 8'd5, tie: 1'b1,
                   exp: {8'd32, 8'd29, 8'h45, 8'd23, 8'd20, 8'd17, 8'd14, 8'h45, 8'd8, 8'd5},
                   cidx: 4'd2, cmax: 8'h45};

        rst = 1'b1; start = 1'b0; res_ready = 1'b1; pool_in = '0;
        for (int k = 0; k < N_OUT; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, res_valid, w_rd_en, w_rd_addr, res_idx, res_data, class_idx, class_max}, 0);
        chk("reset_lin", (pool_lin == '0) && (weight_lin == '0), 1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            load_rows(tbl[i].pool, tbl[i].tie);
            run_frame({27{tbl[i].pool}}, tbl[i].exp, tbl[i].cidx, tbl[i].cmax, -1, 0, -1, -1);
        end

        // Backpressure on neuron 1 for five cycles.
        load_rows(tbl[0].pool, 1'b0);
        run_frame({27{tbl[0].pool}}, tbl[0].exp, tbl[0].cidx, tbl[0].cmax, 1, 5, -1, -1);

        // Starts during EVAL and during DONE are ignored; the one right after DONE is taken.
        run_frame({27{tbl[0].pool}}, tbl[0].exp, tbl[0].cidx, tbl[0].cmax, -1, 0, 3, 41);
        for (int k = 0; k < N_OUT; k++) e[k*8 +: 8] = 8'(7 + 3 * k);
        run_frame({27{8'd7}}, e, 4'd9, 8'd34, -1, 0, -1, -1);

        // Reset while neuron 4 is being offered.
        dc0 = done_cnt;
        pool_in = {27{8'd5}};
        start = 1'b1;
        t0 = cyc;
        step();
        guard = 0;
        while (!(res_valid && res_idx == 4'd4) && guard < 60) begin
            step();
            guard++;
        end
        chk("mid_reset_reach_k4", cyc - t0, 20);
        rst = 1'b1;
        step();
        chk("mid_reset_outs", {busy, done, res_valid, w_rd_en, w_rd_addr, res_idx, res_data, class_idx, class_max}, 0);
        chk("mid_reset_lin", (pool_lin == '0) && (weight_lin == '0), 1);
        step();
        rst = 1'b0;
        repeat (60) step();
        chk("no_done_after_reset", done_cnt - dc0, 0);
        chk("idle_after_reset", busy, 0);

        // Dot-product datapath with random int8 vectors.
        dp_real = 1'b1;
        for (int r = 0; r < 2; r++) begin
            pv = rvec();
            for (int k = 0; k < N_OUT; k++) mem[k] = rvec();
            bi = 0;
            bm = 8'h80;
            for (int k = 0; k < N_OUT; k++) begin
                e[k*8 +: 8] = dot(pv, mem[k]);
                if ($signed(e[k*8 +: 8]) > $signed(bm)) begin
                    bm = e[k*8 +: 8];
                    bi = k;
                end
            end
            run_frame(pv, e, 4'(bi), bm, -1, 0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
